pipe_stage_seq: RTL and testbench

Parametrised stage sequencer with a multi-lane running-argmax tracker. It is the next-generation controller for the fp16 similarity pipeline. The block counts pipeline steps, maps each step onto one of NUM_STAGES stages using boundaries latched at start, and drives the per-stage reconfigurable-tile mode bit. During programmable tracking stages it keeps, per lane, the maximum fp16 score and its id, then thresholds that maximum to produce a match id and score.

---
 rtl/pipe_stage_seq.sv | 157 +++++++++++++++
 tb/tb_pipe_stage_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_seq.sv
// Stage sequencer for the fp16 similarity pipeline: counts steps, maps them onto stages
// from boundaries latched at start, and tracks a per-lane running argmax of fp16 scores.
module pipe_stage_seq #(
  parameter int NUM_STAGES = 8,
  parameter int STEP_W     = 16,
  parameter int WIDTH      = 16,
  parameter int ID_W       = 16,
  parameter int LANES      = 4,
  parameter int NO_MATCH   = 4096
) (
  input  logic                             CLK_i,
  input  logic                             RST_i,
  input  logic                             start_i,
  input  logic                             stall_i,
  input  logic [(NUM_STAGES-1)*STEP_W-1:0] bound_i,
  input  logic [NUM_STAGES-1:0]            mode_mask_i,
  input  logic [NUM_STAGES-1:0]            track_mask_i,
  input  logic [WIDTH-1:0]                 thresh_i,
  input  logic                             score_valid_i,
  input  logic [LANES*WIDTH-1:0]           score_i,
  input  logic [ID_W-1:0]                  id_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [STEP_W-1:0]                step_o,
  output logic [$clog2(NUM_STAGES)-1:0]    stage_o,
  output logic                             mode_o,
  output logic [LANES*ID_W-1:0]            match_id_o,
  output logic [LANES*WIDTH-1:0]           match_score_o
);

  localparam int SEL_W = $clog2(NUM_STAGES);
  localparam int NB    = NUM_STAGES - 1;
  localparam logic [WIDTH-1:0] NEG_INF  = WIDTH'(16'hFC00);
  localparam logic [WIDTH-1:0] ONE_FP   = WIDTH'(16'h3C00);
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ID_W-1:0]  NO_ID    = ID_W'(NO_MATCH);
  localparam logic [SEL_W-1:0] LAST_STG = SEL_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Sign-magnitude to monotonic unsigned key; -0 is folded onto +0 so they compare equal.
  function automatic logic [WIDTH-1:0] fp_key(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] v;
    v = (x == SIGN_BIT) ? '0 : x;
    return v[WIDTH-1] ? ~v : (v | SIGN_BIT);
  endfunction

  function automatic logic fp_is_nan(input logic [WIDTH-1:0] x);
    return (x[WIDTH-2 -: 5] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  state_t              state_q, state_nx;
  logic [STEP_W-1:0]   step_q;
  logic [STEP_W-1:0]   bnd_q [NB];
  logic [NUM_STAGES-1:0] mode_mask_q, track_mask_q;
  logic [WIDTH-1:0]    thresh_q;
  logic [SEL_W-1:0]    stage_c;
  logic                track_en;

  logic [WIDTH-1:0]    max_q [LANES];
  logic [ID_W-1:0]     id_q  [LANES];
  logic [LANES-1:0]    hit_q;
  logic [LANES-1:0]    upd_c;

  // Stage is the number of boundaries already passed by the registered step.
  always_comb begin
    stage_c = '0;
    for (int k = 0; k < NB; k++) begin
      if (step_q > bnd_q[k]) stage_c = stage_c + SEL_W'(1);
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) state_q <= IDLE;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (start_i) state_nx = RUN;
      RUN:     if (start_i) state_nx = RUN;
               else if (stage_c == LAST_STG) state_nx = DONE;
      DONE:    if (start_i) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
    mode_o = (state_q == RUN) ? mode_mask_q[stage_c] : 1'b1;
  end

  // Control: step counter (saturating) and configuration latched on start.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      step_q       <= '0;
      mode_mask_q  <= '0;
      track_mask_q <= '0;
      thresh_q     <= '0;
      for (int k = 0; k < NB; k++) bnd_q[k] <= '0;
    end else if (start_i) begin
      step_q       <= '0;
      mode_mask_q  <= mode_mask_i;
      track_mask_q <= track_mask_i;
      thresh_q     <= thresh_i;
      for (int k = 0; k < NB; k++) bnd_q[k] <= bound_i[k*STEP_W +: STEP_W];
    end else if (state_q == RUN && !stall_i && step_q != '1) begin
      step_q <= step_q + STEP_W'(1);
    end
  end

  assign step_o  = step_q;
  assign stage_o = stage_c;

  // Final-stage cycle is excluded so late scores never alter a finished run.
  assign track_en = (state_q == RUN) && !stall_i && score_valid_i &&
                    track_mask_q[stage_c] && (stage_c != LAST_STG);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      upd_c[l] = !fp_is_nan(score_i[l*WIDTH +: WIDTH]) &&
                 (fp_key(score_i[l*WIDTH +: WIDTH]) > fp_key(max_q[l]));
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i || start_i) hit_q <= '0;
    else if (track_en) hit_q <= hit_q | upd_c;
  end

  always_ff @(posedge CLK_i) begin
    for (int l = 0; l < LANES; l++) begin
      if (start_i) begin
        max_q[l] <= NEG_INF;
        id_q[l]  <= NO_ID;
      end else if (track_en && upd_c[l]) begin
        max_q[l] <= score_i[l*WIDTH +: WIDTH];
        id_q[l]  <= id_i;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (hit_q[l] && (fp_key(max_q[l]) >= fp_key(thresh_q))) begin
        match_id_o[l*ID_W +: ID_W]     = id_q[l];
        match_score_o[l*WIDTH +: WIDTH] = max_q[l];
      end else begin
        match_id_o[l*ID_W +: ID_W]     = NO_ID;
        match_score_o[l*WIDTH +: WIDTH] = ONE_FP;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_seq.sv
// Directed bench for pipe_stage_seq: stage sequencing, stall, argmax tracking, reset.
module tb_pipe_stage_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stall;
  logic [111:0] bound;
  logic [7:0]   mode_mask;
  logic [7:0]   track_mask;
  logic [15:0]  thresh;
  logic         score_valid;
  logic [63:0]  score;
  logic [15:0]  id;
  logic         busy, done, mode;
  logic [15:0]  step;
  logic [2:0]   stage;
  logic [63:0]  match_id, match_score;

  int n_run  = 0;
  int n_fail = 0;

  pipe_stage_seq dut (
    .CLK_i         (clk),
    .RST_i         (rst),
    .start_i       (start),
    .stall_i       (stall),
    .bound_i       (bound),
    .mode_mask_i   (mode_mask),
    .track_mask_i  (track_mask),
    .thresh_i      (thresh),
    .score_valid_i (score_valid),
    .score_i       (score),
    .id_i          (id),
    .busy_o        (busy),
    .done_o        (done),
    .step_o        (step),
    .stage_o       (stage),
    .mode_o        (mode),
    .match_id_o    (match_id),
    .match_score_o (match_score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bounds_all(input logic [15:0] b);
    for (int k = 0; k < 7; k++) bound[k*16 +: 16] = b;
  endtask

  task automatic feed(input logic [15:0] s0, input logic [15:0] s1,
                      input logic [15:0] s2, input logic [15:0] s3, input logic [15:0] i);
    score_valid = 1'b1;
    score = {s3, s2, s1, s0};
    id = i;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_done"},  {63'd0, done}, 64'd0);
    check({tag, "_step"},  {48'd0, step}, 64'd0);
    check({tag, "_stage"}, {61'd0, stage}, 64'd0);
    check({tag, "_mode"},  {63'd0, mode}, 64'd1);
    check({tag, "_mid"},   match_id, {4{16'h1000}});
    check({tag, "_msc"},   match_score, {4{16'h3C00}});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mm;
    int         exp_stage;

    rst = 1'b1; start = 1'b0; stall = 1'b0; bound = '0; mode_mask = '0;
    track_mask = '0; thresh = '0; score_valid = 1'b0; score = '0; id = '0;
    tick(); tick();
    check_reset_outputs("rst0");
    rst = 1'b0;
    tick();

    // Run 1: boundaries 2,4,...,14, no stall
    for (int k = 0; k < 7; k++) bound[k*16 +: 16] = 16'(2*k + 2);
    mm = 8'hA6; mode_mask = mm; track_mask = 8'h00; thresh = 16'h3BD7;
    start = 1'b1; tick(); start = 1'b0;
    for (int s = 0; s < 16; s++) begin
      exp_stage = (s < 3) ? 0 : (s - 1) / 2;
      check($sformatf("r1_step%0d", s),  {48'd0, step}, 64'(s));
      check($sformatf("r1_stage%0d", s), {61'd0, stage}, 64'(exp_stage));
      check($sformatf("r1_mode%0d", s),  {63'd0, mode}, {63'd0, mm[exp_stage]});
      check($sformatf("r1_done%0d", s),  {63'd0, done}, 64'd0);
      tick();
    end
    check("r1_done_end", {63'd0, done}, 64'd1);
    check("r1_busy_end", {63'd0, busy}, 64'd0);
    check("r1_mode_end", {63'd0, mode}, 64'd1);

    // Run 2: restart from DONE, stall 5 cycles at step 7
    start = 1'b1; tick(); start = 1'b0;
    check("r2_busy", {63'd0, busy}, 64'd1);
    check("r2_step0", {48'd0, step}, 64'd0);
    for (int i = 0; i < 7; i++) tick();
    check("r2_step7", {48'd0, step}, 64'd7);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("r2_hold%0d", i), {48'd0, step}, 64'd7);
      check($sformatf("r2_hstg%0d", i), {61'd0, stage}, 64'd3);
    end
    stall = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("r2_step15", {48'd0, step}, 64'd15);
    check("r2_notdone", {63'd0, done}, 64'd0);
    tick();
    check("r2_done", {63'd0, done}, 64'd1);

    // Run 3: argmax tracking, equal boundaries at 10, threshold 0x3BD7
    set_bounds_all(16'd10); mode_mask = 8'h00; track_mask = 8'hFF; thresh = 16'h3BD7;
    start = 1'b1; tick(); start = 1'b0;
    feed(16'h3800, 16'h3B00, 16'h7E00, 16'hC000, 16'd1);
    check("r3_l0_first", {48'd0, match_id[15:0]}, 64'h1000);
    feed(16'h3BF0, 16'h3000, 16'h8000, 16'hBC00, 16'd2);
    feed(16'h3BF0, 16'h3A00, 16'h0000, 16'h4000, 16'd3);
    feed(16'h3A00, 16'h3B00, 16'hBC00, 16'hC400, 16'd4);
    score_valid = 1'b0;
    check("r3_l0_id",  {48'd0, match_id[15:0]},    64'd2);
    check("r3_l0_sc",  {48'd0, match_score[15:0]}, 64'h3BF0);
    check("r3_l1_id",  {48'd0, match_id[31:16]},    64'd4096);
    check("r3_l1_sc",  {48'd0, match_score[31:16]}, 64'h3C00);
    check("r3_l2_id",  {48'd0, match_id[47:32]},    64'd4096);
    check("r3_l3_id",  {48'd0, match_id[63:48]},    64'd3);
    check("r3_l3_sc",  {48'd0, match_score[63:48]}, 64'h4000);
    stall = 1'b1;
    feed(16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 16'd9);
    stall = 1'b0; score_valid = 1'b0;
    check("r3_stall_l0", {48'd0, match_id[15:0]}, 64'd2);
    check("r3_stall_step", {48'd0, step}, 64'd4);
    for (int i = 0; i < 7; i++) tick();
    check("r3_step11", {48'd0, step}, 64'd11);
    check("r3_stage7", {61'd0, stage}, 64'd7);
    feed(16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 16'd9);
    score_valid = 1'b0;
    check("r3_done", {63'd0, done}, 64'd1);
    check("r3_final_l0", {48'd0, match_id[15:0]}, 64'd2);
    check("r3_final_l1", {48'd0, match_id[31:16]}, 64'd4096);
    tick(); tick(); tick();
    check("r3_hold_mid", match_id, {16'd3, 16'd4096, 16'd4096, 16'd2});
    check("r3_hold_msc", match_score, {16'h4000, 16'h3C00, 16'h3C00, 16'h3BF0});

    // Run 4: signed zero and NaN handling, threshold +0
    thresh = 16'h0000;
    start = 1'b1; tick(); start = 1'b0;
    feed(16'h0000, 16'h0000, 16'h7E00, 16'h0000, 16'd1);
    check("r4_nan_only", {48'd0, match_id[47:32]}, 64'd4096);
    feed(16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'd2);
    feed(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd3);
    score_valid = 1'b0;
    check("r4_l2_id", {48'd0, match_id[47:32]},    64'd2);
    check("r4_l2_sc", {48'd0, match_score[47:32]}, 64'h8000);
    check("r4_l0_id", {48'd0, match_id[15:0]},     64'd1);

    // Run 5: reset mid-run has priority over start, then all-zero boundaries
    start = 1'b1; tick(); start = 1'b0;
    feed(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'd5);
    score_valid = 1'b0;
    check("r5_pre_rst", {48'd0, match_id[15:0]}, 64'd5);
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    check_reset_outputs("r5_rst");
    tick();
    check("r5_idle", {63'd0, busy}, 64'd0);
    set_bounds_all(16'd0); mode_mask = 8'h80; track_mask = 8'h00;
    start = 1'b1; tick(); start = 1'b0;
    check("r5_s0_stage", {61'd0, stage}, 64'd0);
    check("r5_s0_mode",  {63'd0, mode}, 64'd0);
    check("r5_s0_mid",   match_id, {4{16'h1000}});
    tick();
    check("r5_s1_step",  {48'd0, step}, 64'd1);
    check("r5_s1_stage", {61'd0, stage}, 64'd7);
    check("r5_s1_mode",  {63'd0, mode}, 64'd1);
    tick();
    check("r5_done", {63'd0, done}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
